// File: rtl/paint_seq_pkg.sv
// Shared types and helpers for the frame-synchronous paint source sequencer.
package paint_seq_pkg;

  typedef enum logic [1:0] {
    SHOW = 2'd0,
    PEND = 2'd1,
    MUTE = 2'd2
  } state_t;

  // Width needed to index n items, never less than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/paint_sequencer_debounce.sv
// Button synchroniser and debouncer; emits one pulse per stable rising press.
module paint_sequencer_debounce #(
  parameter int unsigned DB_BITS = 18
) (
  input  logic clk_pix,
  input  logic rst_pix_n,
  input  logic btn_next,
  output logic btn_stb
);

  logic [1:0]         sync_q;
  logic               stable_q;
  logic [DB_BITS-1:0] db_cnt_q;
  logic               differ_c;
  logic               cnt_full_c;

  assign differ_c   = sync_q[1] ^ stable_q;
  assign cnt_full_c = &db_cnt_q;

  // Stable level only follows the synced input after 2^DB_BITS differing cycles.
  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      sync_q   <= 2'b00;
      stable_q <= 1'b0;
      db_cnt_q <= '0;
      btn_stb  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_next};
      btn_stb <= 1'b0;
      if (!differ_c) begin
        db_cnt_q <= '0;
      end else if (cnt_full_c) begin
        stable_q <= sync_q[1];
        db_cnt_q <= '0;
        btn_stb  <= sync_q[1];
      end else begin
        db_cnt_q <= db_cnt_q + DB_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/paint_sequencer.sv
// Selects the active pattern painter, switching only at frame start and muting after each switch.
module paint_sequencer
  import paint_seq_pkg::*;
#(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned DWELL_FRAMES = 300,
  parameter int unsigned BLANK_FRAMES = 2,
  parameter int unsigned DB_BITS      = 18,
  localparam int unsigned SELW        = sel_width(NUM_SRC)
) (
  input  logic            clk_pix,
  input  logic            rst_pix_n,
  input  logic            frame,
  input  logic            btn_next,
  input  logic            auto_en,
  output logic [SELW-1:0] src_sel,
  output logic            mute,
  output logic            switch_stb,
  output logic            btn_stb
);

  localparam int unsigned DW_W = sel_width(DWELL_FRAMES);
  localparam int unsigned MC_W = sel_width(BLANK_FRAMES + 32'd1);

  state_t          state_q, state_d;
  logic [SELW-1:0] src_sel_q, src_sel_d;
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic [MC_W-1:0] mute_cnt_q, mute_cnt_d;
  logic            pend_q, pend_d;
  logic            mute_q, mute_d;
  logic            switch_stb_q, switch_stb_d;
  logic            advance_c;

  paint_sequencer_debounce #(
    .DB_BITS (DB_BITS)
  ) u_debounce (
    .clk_pix   (clk_pix),
    .rst_pix_n (rst_pix_n),
    .btn_next  (btn_next),
    .btn_stb   (btn_stb)
  );

  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      state_q      <= SHOW;
      src_sel_q    <= '0;
      dwell_q      <= '0;
      mute_cnt_q   <= '0;
      pend_q       <= 1'b0;
      mute_q       <= 1'b0;
      switch_stb_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_sel_q    <= src_sel_d;
      dwell_q      <= dwell_d;
      mute_cnt_q   <= mute_cnt_d;
      pend_q       <= pend_d;
      mute_q       <= mute_d;
      switch_stb_q <= switch_stb_d;
    end
  end

  // Decisions use the registered pend, so a press on a frame cycle waits for the next frame.
  always_comb begin
    state_d      = state_q;
    src_sel_d    = src_sel_q;
    dwell_d      = dwell_q;
    mute_cnt_d   = mute_cnt_q;
    pend_d       = pend_q | btn_stb;
    mute_d       = mute_q;
    switch_stb_d = 1'b0;
    advance_c    = 1'b0;

    unique case (state_q)
      SHOW, PEND: begin
        if (frame && (pend_q || (auto_en && (dwell_q == DW_W'(DWELL_FRAMES - 32'd1))))) begin
          advance_c = 1'b1;
        end else begin
          if (!auto_en) begin
            dwell_d = '0;
          end else if (frame) begin
            dwell_d = dwell_q + DW_W'(1);
          end
          if (pend_d) begin
            state_d = PEND;
          end
        end
      end
      MUTE: begin
        dwell_d = '0;
        if (frame) begin
          if (mute_cnt_q == MC_W'(1)) begin
            mute_d     = 1'b0;
            mute_cnt_d = '0;
            state_d    = pend_d ? PEND : SHOW;
          end else begin
            mute_cnt_d = mute_cnt_q - MC_W'(1);
          end
        end
      end
      default: state_d = SHOW;
    endcase

    if (advance_c) begin
      src_sel_d    = (src_sel_q == SELW'(NUM_SRC - 32'd1)) ? '0 : src_sel_q + SELW'(1);
      pend_d       = btn_stb;
      dwell_d      = '0;
      switch_stb_d = 1'b1;
      if (BLANK_FRAMES > 32'd0) begin
        mute_d     = 1'b1;
        mute_cnt_d = MC_W'(BLANK_FRAMES);
        state_d    = MUTE;
      end else begin
        state_d    = btn_stb ? PEND : SHOW;
      end
    end
  end

  assign src_sel    = src_sel_q;
  assign mute       = mute_q;
  assign switch_stb = switch_stb_q;

endmodule

// File: doc/paint_sequencer.md
Name: paint_sequencer

Overview:
- Frame-synchronous controller that shares the display paint stage between NUM_SRC pattern painters (flags, test cards) in the clk_pix domain.
- Selects which painter drives display colour. Advances on a debounced button press or after an automatic dwell period.
- Changes selection only at frame start, to avoid tearing. Mutes output for BLANK_FRAMES frames after each switch.
- Sits between the display timing generator (frame pulse) and the colour mux ahead of the output registers.

Parameters:
- NUM_SRC, 4: number of painters; must be at least 2. SELW = $clog2(NUM_SRC).
- DWELL_FRAMES, 300: frames shown per source in auto mode; must be at least 1.
- BLANK_FRAMES, 2: frames muted after a switch; 0 disables muting.
- DB_BITS, 18: debounce counter width; 2^DB_BITS clk_pix cycles of stable input are required.

Ports:
- clk_pix  in  1  pixel clock; the only clock.
- rst_pix_n  in  1  reset; synchronous, active-low.
- frame  in  1  one-cycle pulse at the start of each frame (sx=0, sy=0).
- btn_next  in  1  raw asynchronous button, active-high.
- auto_en  in  1  enables automatic advance.
- src_sel  out  SELW  selected painter index.
- mute  out  1  colour mux forces black while high.
- switch_stb  out  1  one-cycle pulse on each cycle src_sel changes.
- btn_stb  out  1  one-cycle pulse per debounced press; for status LED and testbench.

Behaviour:
- Reset (rst_pix_n low at a clk_pix edge) forces:
  - src_sel=0, mute=0, switch_stb=0, btn_stb=0.
  - state=SHOW, dwell_cnt=0, pend=0, mute_cnt=0.
  - Debounce synchroniser, stable level and counter all cleared to 0.
- Reset mid-MUTE or mid-PEND aborts immediately; there is no pending carry-over.
- Button path:
  - Synchronise btn_next through 2 flops.
  - If the synced value differs from the stable level, increment db_cnt; otherwise clear db_cnt.
  - When db_cnt reaches all-ones while still differing, update the stable level and clear db_cnt.
  - A stable 0->1 transition pulses btn_stb for 1 cycle.
  - Latency from btn_next edge to btn_stb is 2 + 2^DB_BITS cycles. Any shorter glitch produces no pulse.
- A btn_stb pulse sets pend=1. Multiple presses before the pending request is serviced coalesce into one advance.
- FSM states are SHOW, PEND and MUTE. Every transition below happens only on a frame=1 cycle.
- SHOW:
  - If pend=1, advance.
  - Else if auto_en=1 and dwell_cnt==DWELL_FRAMES-1, advance.
  - Else if auto_en=1, dwell_cnt++.
  - If auto_en=0, dwell_cnt is held at 0.
  - A button press and a dwell expiry on the same frame produce exactly one advance.
- PEND:
  - Entered from SHOW on btn_stb, used for visibility only.
  - Behaves exactly as SHOW with pend=1: the next frame pulse advances.
- Advance:
  - src_sel <= (src_sel==NUM_SRC-1) ? 0 : src_sel+1, wrapping.
  - Clear pend and dwell_cnt. Pulse switch_stb.
  - If BLANK_FRAMES>0: set mute=1, load mute_cnt=BLANK_FRAMES, go to MUTE. Otherwise go to SHOW.
  - All of these outputs are registered: a frame pulse at cycle t yields the new src_sel, switch_stb=1 and mute=1 at t+1.
- MUTE:
  - Each frame pulse decrements mute_cnt.
  - When mute_cnt reaches 1 at a frame pulse: clear mute (at t+1) and go to SHOW, or to PEND if pend=1.
  - Button presses during MUTE set pend. The pending advance is applied at the first frame pulse after MUTE exits, never earlier.
  - dwell_cnt holds at 0 during MUTE.
- A frame pulse and btn_stb on the same cycle: the press is latched into pend and is serviced at the following frame pulse, not the current one.
- All counters saturate or wrap only as stated above; no other arithmetic is permitted.

Decomposition:
- Package paint_seq_pkg holds the state enum {SHOW, PEND, MUTE} and the SELW helper function.
- One sub-module, debounce: synchroniser, counter and stable level, producing btn_stb. Parameter DB_BITS.
- The FSM, dwell counter, mute counter and select register stay in paint_sequencer.

Test Plan:
- Reset: hold rst_pix_n=0 for 3 cycles with random inputs -> src_sel=0, mute=0, switch_stb=0, btn_stb=0 on the first cycle after release.
- Debounce (DB_BITS=4): a btn_next high pulse of 10 cycles -> no btn_stb. Hold high for 20 cycles -> exactly one btn_stb, 18 cycles after the edge.
- Button advance (BLANK_FRAMES=2): press, then frame pulses -> at the 1st frame after btn_stb:
  - src_sel 0->1, switch_stb=1 for 1 cycle, mute=1.
  - mute falls after the 2nd subsequent frame pulse.
- Auto wrap (NUM_SRC=3, DWELL_FRAMES=3, BLANK_FRAMES=0, auto_en=1): 9 frame pulses -> src_sel sequence 0,0,0,1,1,1,2,2,2, then 0 on the 10th. Exactly 3 switch_stb pulses over the 9 frames.
- Simultaneous and coalesce: 3 presses in one frame, with dwell expiring on that same frame -> exactly one advance. A press during MUTE -> advance only on the first frame after mute clears.
- Reset mid-MUTE with pend=1 -> src_sel=0, mute=0, and no advance on the following frames with auto_en=0.
